// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared opcode constants and FSM state encoding for the hazard/stall controller.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package hazard_stall_ctrl_pkg;

    // Opcodes the source-use decoder recognises (6-bit MIPS major opcode).
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // Load-use FSM: RUN is the normal state; LU_HOLD covers the extra
    // bubbles beyond the first when more than one bubble is configured.
    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_LU_HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/hazard_stall_ctrl_src_use_decode.sv
// Decodes which source registers (rs, rt) an instruction in ID actually reads.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the opcode every cycle.
//
// Ports:
//   op     - opcode of the instruction in ID
//   use_rs - instruction reads rs
//   use_rt - instruction reads rt
module hazard_stall_ctrl_src_use_decode
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  logic [OP_W-1:0] op,
    output logic            use_rs,
    output logic            use_rt
);

    always_comb begin
        use_rs = 1'b0;
        use_rt = 1'b0;
        case (op)
            OP_W'(OP_RTYPE),
            OP_W'(OP_BEQ),
            OP_W'(OP_SW): begin
                use_rs = 1'b1;
                use_rt = 1'b1;
            end
            // lw reads only its base register; its rt is a destination.
            OP_W'(OP_ADDI),
            OP_W'(OP_LW): begin
                use_rs = 1'b1;
            end
            default: begin
                use_rs = 1'b0;
                use_rt = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Load-use hazard detector with configurable bubble count, MEM-busy freeze,
// taken-branch flush and a saturating stall-cycle statistics counter.
// Latency: outputs are combinational from state and inputs (same-cycle stall);
//          Backpressure: DMem_busy_i freezes PC..EX/MEM and holds the FSM.
//
// Ports:
//   clk_i, rst_i               - clock, async active-high reset
//   Op_i, IFID_Rs/RtAddr_i     - instruction in ID
//   IDEX_RtAddr_i, IDEX_MemRead_i - instruction in EX (load destination)
//   DMem_busy_i                - MEM-stage access not complete this cycle
//   Branch_taken_i             - branch in ID resolved taken
//   Stat_clr_i                 - synchronous clear of Stall_cnt_o
//   PC/IFID/IDEX/EXMEM_stall_o - hold the respective pipeline registers
//   IDEX_bubble_o              - load NOP controls into ID/EX
//   IFID_flush_o               - zero IF/ID
//   Stall_cnt_o                - saturating count of cycles with PC held
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int OP_W       = 6,
    parameter int REG_W      = 5,
    parameter int LU_BUBBLES = 1,
    parameter int CNT_W      = 3,
    parameter int STAT_W     = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [OP_W-1:0]   Op_i,
    input  logic [REG_W-1:0]  IFID_RsAddr_i,
    input  logic [REG_W-1:0]  IFID_RtAddr_i,
    input  logic [REG_W-1:0]  IDEX_RtAddr_i,
    input  logic              IDEX_MemRead_i,
    input  logic              DMem_busy_i,
    input  logic              Branch_taken_i,
    input  logic              Stat_clr_i,
    output logic              PC_stall_o,
    output logic              IFID_stall_o,
    output logic              IDEX_bubble_o,
    output logic              IDEX_stall_o,
    output logic              EXMEM_stall_o,
    output logic              IFID_flush_o,
    output logic [STAT_W-1:0] Stall_cnt_o
);

    // Elaboration-time parameter sanity check.
    if (LU_BUBBLES < 1 || LU_BUBBLES > 7 || (LU_BUBBLES - 1) >= (1 << CNT_W)) begin : g_bad_param
        $error("hazard_stall_ctrl: LU_BUBBLES must be 1..7 and fit in CNT_W bits");
    end

    // Only configurations with more than one bubble ever use LU_HOLD.
    localparam bit MULTI_BUBBLE = (LU_BUBBLES > 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LU_BUBBLES - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic use_rs;
    logic use_rt;
    logic hazard;
    logic lu_stall;

    hazard_stall_ctrl_src_use_decode #(
        .OP_W (OP_W)
    ) u_src_use_decode (
        .op     (Op_i),
        .use_rs (use_rs),
        .use_rt (use_rt)
    );

    // r0 is hard-wired to zero, so a load "into" it never creates a dependency.
    assign hazard = IDEX_MemRead_i
                  && (IDEX_RtAddr_i != '0)
                  && ((use_rs && (IFID_RsAddr_i == IDEX_RtAddr_i))
                   || (use_rt && (IFID_RtAddr_i == IDEX_RtAddr_i)));

    // The first bubble is issued from RUN in the cycle the hazard appears;
    // LU_HOLD supplies the remaining LU_BUBBLES-1 regardless of ID contents.
    assign lu_stall = ((state == ST_RUN) && hazard) || (state == ST_LU_HOLD);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Bubbles are only counted on cycles where the pipe actually advances;
    // while MEM is busy the FSM and counter are frozen.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (!DMem_busy_i) begin
            case (state)
                ST_RUN: begin
                    if (hazard && MULTI_BUBBLE) begin
                        state_nxt = ST_LU_HOLD;
                        cnt_nxt   = CNT_LOAD;
                    end
                end
                ST_LU_HOLD: begin
                    cnt_nxt = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state_nxt = ST_RUN;
                    end
                end
                default: begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Priority: MEM busy freeze > load-use bubble > branch flush.
    always_comb begin
        PC_stall_o    = 1'b0;
        IFID_stall_o  = 1'b0;
        IDEX_bubble_o = 1'b0;
        IDEX_stall_o  = 1'b0;
        EXMEM_stall_o = 1'b0;
        IFID_flush_o  = 1'b0;
        if (DMem_busy_i) begin
            PC_stall_o    = 1'b1;
            IFID_stall_o  = 1'b1;
            IDEX_stall_o  = 1'b1;
            EXMEM_stall_o = 1'b1;
        end else if (lu_stall) begin
            PC_stall_o    = 1'b1;
            IFID_stall_o  = 1'b1;
            IDEX_bubble_o = 1'b1;
        end else begin
            // A branch that waited on a load is resolved again here once
            // the bubbles have drained.
            IFID_flush_o  = Branch_taken_i;
        end
    end

    // Saturating stall statistics; clear takes precedence over counting.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            Stall_cnt_o <= '0;
        end else if (Stat_clr_i) begin
            Stall_cnt_o <= '0;
        end else if (PC_stall_o && (Stall_cnt_o != '1)) begin
            Stall_cnt_o <= Stall_cnt_o + STAT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench: three configurations (1, 3 and 7 bubbles; the last with
// a 4-bit statistics counter) driven in lockstep and compared to a per-instance
// behavioural model, plus directed scenarios with fixed expected values.
module tb_hazard_stall_ctrl;

    logic       clk;
    logic       rst;
    logic [5:0] op;
    logic [4:0] rs, rt, idex_rt;
    logic       memread, busy, branch, clr;

    logic        pc_a, ifid_a, bub_a, idex_a, exmem_a, fl_a;
    logic        pc_b, ifid_b, bub_b, idex_b, exmem_b, fl_b;
    logic        pc_c, ifid_c, bub_c, idex_c, exmem_c, fl_c;
    logic [15:0] cnt_a, cnt_b;
    logic [3:0]  cnt_c;

    logic [5:0]  ov [3];
    logic [15:0] cv [3];

    int n_chk = 0;
    int n_bad = 0;

    // Model state per instance: bubbles still owed, and statistics value.
    int lu_cfg  [3] = '{1, 3, 7};
    int sat_cfg [3] = '{65535, 65535, 15};
    int pend    [3];
    int scnt    [3];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    hazard_stall_ctrl #(.LU_BUBBLES(1), .STAT_W(16)) u_a (
        .clk_i(clk), .rst_i(rst), .Op_i(op), .IFID_RsAddr_i(rs), .IFID_RtAddr_i(rt),
        .IDEX_RtAddr_i(idex_rt), .IDEX_MemRead_i(memread), .DMem_busy_i(busy),
        .Branch_taken_i(branch), .Stat_clr_i(clr), .PC_stall_o(pc_a), .IFID_stall_o(ifid_a),
        .IDEX_bubble_o(bub_a), .IDEX_stall_o(idex_a), .EXMEM_stall_o(exmem_a),
        .IFID_flush_o(fl_a), .Stall_cnt_o(cnt_a));

    hazard_stall_ctrl #(.LU_BUBBLES(3), .STAT_W(16)) u_b (
        .clk_i(clk), .rst_i(rst), .Op_i(op), .IFID_RsAddr_i(rs), .IFID_RtAddr_i(rt),
        .IDEX_RtAddr_i(idex_rt), .IDEX_MemRead_i(memread), .DMem_busy_i(busy),
        .Branch_taken_i(branch), .Stat_clr_i(clr), .PC_stall_o(pc_b), .IFID_stall_o(ifid_b),
        .IDEX_bubble_o(bub_b), .IDEX_stall_o(idex_b), .EXMEM_stall_o(exmem_b),
        .IFID_flush_o(fl_b), .Stall_cnt_o(cnt_b));

    hazard_stall_ctrl #(.LU_BUBBLES(7), .CNT_W(3), .STAT_W(4)) u_c (
        .clk_i(clk), .rst_i(rst), .Op_i(op), .IFID_RsAddr_i(rs), .IFID_RtAddr_i(rt),
        .IDEX_RtAddr_i(idex_rt), .IDEX_MemRead_i(memread), .DMem_busy_i(busy),
        .Branch_taken_i(branch), .Stat_clr_i(clr), .PC_stall_o(pc_c), .IFID_stall_o(ifid_c),
        .IDEX_bubble_o(bub_c), .IDEX_stall_o(idex_c), .EXMEM_stall_o(exmem_c),
        .IFID_flush_o(fl_c), .Stall_cnt_o(cnt_c));

    assign ov[0] = {pc_a, ifid_a, bub_a, idex_a, exmem_a, fl_a};
    assign ov[1] = {pc_b, ifid_b, bub_b, idex_b, exmem_b, fl_b};
    assign ov[2] = {pc_c, ifid_c, bub_c, idex_c, exmem_c, fl_c};
    assign cv[0] = cnt_a;
    assign cv[1] = cnt_b;
    assign cv[2] = {12'd0, cnt_c};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Hazard straight from the rules: which opcodes read which sources.
    function automatic bit model_hazard();
        bit rs_used = op inside {6'd0, 6'd4, 6'd43, 6'd8, 6'd35};
        bit rt_used = op inside {6'd0, 6'd4, 6'd43};
        return memread && (idex_rt != 0) &&
               ((rs_used && rs == idex_rt) || (rt_used && rt == idex_rt));
    endfunction

    function automatic logic [5:0] model_out(input int i);
        bit lu;
        if (busy) return 6'b110110;
        lu = (pend[i] > 0) || model_hazard();
        return {lu, lu, lu, 1'b0, 1'b0, branch && !lu};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            pend[i] = 0;
            scnt[i] = 0;
        end
    endtask

    task automatic check_model();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("out%0d", i), 32'(ov[i]), 32'(model_out(i)));
            chk($sformatf("cnt%0d", i), 32'(cv[i]), 32'(scnt[i]));
        end
    endtask

    task automatic advance_model();
        bit hz = model_hazard();
        for (int i = 0; i < 3; i++) begin
            logic [5:0] o = model_out(i);
            if (clr) scnt[i] = 0;
            else if (o[5] && scnt[i] < sat_cfg[i]) scnt[i] = scnt[i] + 1;
            if (!busy) begin
                if (pend[i] > 0) pend[i] = pend[i] - 1;
                else if (hz) pend[i] = lu_cfg[i] - 1;
            end
        end
    endtask

    // Inputs are set just after a rising edge; outputs are checked 1ns later.
    task automatic tick();
        #1;
        check_model();
        advance_model();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        op = 6'd63; rs = 0; rt = 0; idex_rt = 0;
        memread = 0; busy = 0; branch = 0; clr = 0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_a", 32'(ov[0]), 0);
        chk("rst_out_c", 32'(ov[2]), 0);
        chk("rst_cnt_b", 32'(cv[1]), 0);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        // lw $2 in EX, add $3,$2,$4 in ID; the load then moves on.
        op = 6'd0; rs = 5'd2; rt = 5'd4; idex_rt = 5'd2; memread = 1;
        tick();
        memread = 0;
        repeat (8) tick();
        chk("lu_cnt_a", 32'(cv[0]), 1);
        chk("lu_cnt_b", 32'(cv[1]), 3);
        chk("lu_cnt_c", 32'(cv[2]), 7);

        // Load into r0 never stalls.
        op = 6'd0; rs = 5'd0; rt = 5'd0; idex_rt = 5'd0; memread = 1;
        #1 chk("r0_nostall_b", 32'(pc_b), 0);
        tick();

        // MEM busy for two cycles during the second bubble.
        idle_inputs(); clr = 1; tick(); clr = 0;
        op = 6'd0; rs = 5'd2; rt = 5'd4; idex_rt = 5'd2; memread = 1;
        tick();
        memread = 0; busy = 1;
        #1 chk("busy_out_b", 32'(ov[1]), 32'(6'b110110));
        repeat (2) tick();
        busy = 0;
        repeat (8) tick();
        chk("busy_cnt_a", 32'(cv[0]), 3);
        chk("busy_cnt_b", 32'(cv[1]), 5);
        chk("busy_cnt_c", 32'(cv[2]), 9);

        // beq $2,$5 waiting on lw $5: no flush until the bubbles drain.
        op = 6'd4; rs = 5'd2; rt = 5'd5; idex_rt = 5'd5; memread = 1; branch = 1;
        #1 chk("br_noflush_b", 32'(fl_b), 0);
        tick();
        memread = 0;
        repeat (2) tick();
        #1 chk("br_flush_b", 32'(fl_b), 1);
        repeat (6) tick();
        idle_inputs();
        tick();

        // Async reset while B sits in LU_HOLD with two bubbles left.
        op = 6'd0; rs = 5'd3; rt = 5'd1; idex_rt = 5'd3; memread = 1;
        tick();
        idle_inputs();
        #2 rst = 1'b1;
        #1;
        chk("arst_out_b", 32'(ov[1]), 0);
        chk("arst_cnt_b", 32'(cv[1]), 0);
        chk("arst_out_c", 32'(ov[2]), 0);
        model_reset();
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        repeat (3) tick();

        // Saturation of the 4-bit counter, then a one-cycle clear.
        busy = 1;
        repeat (20) tick();
        chk("sat_cnt_c", 32'(cv[2]), 15);
        busy = 0; clr = 1;
        tick();
        clr = 0;
        chk("clr_cnt_c", 32'(cv[2]), 0);

        // Randomized traffic with small register numbers to provoke hazards.
        for (int n = 0; n < 3000; n++) begin
            logic [5:0] ops [8];
            ops = '{6'd0, 6'd4, 6'd43, 6'd8, 6'd35, 6'd2, 6'd13, 6'd63};
            op      = ops[$urandom_range(0, 7)];
            rs      = 5'($urandom_range(0, 3));
            rt      = 5'($urandom_range(0, 3));
            idex_rt = 5'($urandom_range(0, 3));
            memread = ($urandom_range(0, 1) == 1);
            busy    = ($urandom_range(0, 4) == 0);
            branch  = ($urandom_range(0, 2) == 0);
            clr     = ($urandom_range(0, 63) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Parametrised successor to the pipeline's load-use hazard detector for the 5-stage MIPS core. It detects load-use hazards in ID and holds IF/ID for a configurable number of bubble cycles, to suit deeper data-memory latency. It also freezes the whole front of the pipe while the MEM-stage access reports busy, and flushes IF/ID on a taken branch. A saturating stall-cycle counter is provided for performance measurement.

Parameters:
OP_W, 6, opcode width
REG_W, 5, register address width
LU_BUBBLES, 1, bubbles inserted per load-use hazard (legal 1..7)
CNT_W, 3, width of internal bubble counter (must hold LU_BUBBLES-1)
STAT_W, 16, width of stall statistics counter

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
Op_i  in  OP_W  opcode of instruction in ID
IFID_RsAddr_i  in  REG_W  rs of instruction in ID
IFID_RtAddr_i  in  REG_W  rt of instruction in ID
IDEX_RtAddr_i  in  REG_W  destination rt of instruction in EX
IDEX_MemRead_i  in  1  instruction in EX is a load
DMem_busy_i  in  1  MEM-stage access not complete this cycle
Branch_taken_i  in  1  branch in ID resolved taken
Stat_clr_i  in  1  synchronous clear of statistics counter
PC_stall_o  out  1  hold PC
IFID_stall_o  out  1  hold IF/ID register
IDEX_bubble_o  out  1  load NOP controls into ID/EX
IDEX_stall_o  out  1  hold ID/EX register
EXMEM_stall_o  out  1  hold EX/MEM register
IFID_flush_o  out  1  zero IF/ID register
Stall_cnt_o  out  STAT_W  cycles with PC_stall_o=1, saturating

Behaviour:
- Source-use decode:
  - R-type 000000, beq 000100, sw 101011: use rs and rt.
  - addi 001000, lw 100011: use rs only.
  - All other opcodes: no use.
- hazard = IDEX_MemRead_i & (IDEX_RtAddr_i != 0) & (rs used & rs==IDEX_RtAddr_i | rt used & rt==IDEX_RtAddr_i).
  - Register 0 never causes a hazard.
- FSM states:
  - RUN to LU_HOLD: in RUN, hazard & !DMem_busy_i & LU_BUBBLES>1. Load cnt=LU_BUBBLES-1.
  - LU_HOLD: cnt decrements each cycle DMem_busy_i=0. Return to RUN on the cycle cnt reaches 1 and decrements.
- Load-use stall is active when RUN&hazard or state==LU_HOLD. It drives PC_stall_o=1, IFID_stall_o=1, IDEX_bubble_o=1.
- Total bubbles per hazard are exactly LU_BUBBLES, counted over non-busy cycles.
- MEM wait, when DMem_busy_i=1:
  - PC, IFID, IDEX and EXMEM stall outputs all =1; IDEX_bubble_o=0; IFID_flush_o=0.
  - FSM state and cnt hold.
  - Highest priority.
- Flush: IFID_flush_o = Branch_taken_i & !DMem_busy_i & !load-use stall.
  - A branch stalled on a load is re-evaluated after the bubbles.
- Priority: DMem_busy > load-use > flush. Simultaneous hazard and busy: freeze only, and hazard is re-evaluated after busy drops.
- Stall_cnt_o:
  - Increments by 1 on every clock with PC_stall_o=1.
  - Saturates at all-ones.
  - Stat_clr_i wins over increment and sets the counter to 0.
- Outputs are combinational from state and inputs. No added latency: stall is asserted in the same cycle the hazard is visible.
- Reset (any time, including mid-LU_HOLD or mid-busy): state=RUN, cnt=0, Stall_cnt_o=0. Outputs then follow the inputs, so all are 0 unless a hazard, busy or branch is present.
- LU_BUBBLES=1 never leaves RUN. Its behaviour matches the single-bubble legacy detector except for the r0 exemption and the lw/sw decode.

Decomposition:
- Shared package/header (e.g. mips_defs): opcode constants OP_RTYPE, OP_BEQ, OP_ADDI, OP_LW, OP_SW and FSM state encodings ST_RUN, ST_LU_HOLD.
- One natural sub-module: src_use_decode (Op_i to use_rs/use_rt), reusable by the forwarding unit.
- The statistics counter stays inline.

Test Plan:
- LU_BUBBLES=1: lw $2 in EX, add $3,$2,$4 in ID -> PC_stall_o/IFID_stall_o/IDEX_bubble_o=1 for exactly 1 cycle, FSM stays RUN, Stall_cnt_o=1.
- LU_BUBBLES=3: same hazard -> stall for 3 consecutive cycles, then 0; Stall_cnt_o=3. With IDEX_RtAddr_i=0 -> no stall.
- LU_BUBBLES=3: DMem_busy_i high for 2 cycles during the second bubble -> all four stalls=1 and bubble=0 for 2 cycles; load-use resumes with 2 bubbles remaining; total PC stall cycles=5.
- beq $2,$5 in ID with lw $5 in EX and Branch_taken_i=1 -> IFID_flush_o=0 during stall; after the bubbles, Branch_taken_i=1 -> IFID_flush_o=1 for 1 cycle.
- rst_i pulsed asynchronously mid-LU_HOLD (cnt=2) -> outputs drop immediately with hazard inputs deasserted, state=RUN, Stall_cnt_o=0.
- STAT_W=4: hold DMem_busy_i for 20 cycles -> Stall_cnt_o saturates at 15; Stat_clr_i for 1 cycle -> 0 on the next edge.
